// File: rtl/core_muldiv_seq.sv
// Iterative 32-bit multiply/divide sequencer for the execute stage.
// MUL: 32 shift-add steps on a 64-bit accumulator. DIV: 32 restoring steps, MSB first.
// A FIXUP cycle applies the result sign and computes the zero flag. The result is then
// held in DONE until the consumer takes it.
module core_muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_div,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] result,
    output logic              sr_zf,
    output logic              div_zero,
    output logic              stall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic [2*DATA_W-1:0] r_acc;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   r_b;        // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic                r_neg;      // final result must be negated
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_result;
    logic                r_zf;
    logic                r_dz;

    // Two's-complement negation.
    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    // Magnitude of an operand. 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? f_neg(v) : v;
    endfunction

    logic [DATA_W-1:0] w_mag_a;
    logic [DATA_W-1:0] w_mag_b;
    logic [DATA_W:0]   w_mul_sum;
    logic [DATA_W:0]   w_div_part;
    logic [DATA_W+1:0] w_div_sub;
    logic              w_div_ok;
    logic              w_unused_sub_msb;
    logic [DATA_W-1:0] w_fix;

    assign w_mag_a   = f_mag(operand_a, req_signed);
    assign w_mag_b   = f_mag(operand_b, req_signed);

    // Shift-add step: add the multiplicand into the upper half when the current multiplier bit is set.
    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);

    // Restoring step: shift the next dividend bit into the remainder and trial-subtract the divisor.
    // The subtraction is one bit wider than the partial remainder so its borrow shows whether the divisor fit.
    assign w_div_part       = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_div_sub        = {1'b0, w_div_part} - {2'b00, r_b};
    assign w_div_ok         = ~w_div_sub[DATA_W+1];
    assign w_unused_sub_msb = w_div_sub[DATA_W];

    assign w_fix = r_neg ? f_neg(r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];

    // Handshake and hold outputs, forced low while reset is asserted.
    assign req_ready  = !rst && (r_state == S_IDLE) && !flush;
    assign stall      = !rst && (r_state != S_IDLE) && !((r_state == S_DONE) && resp_ready);
    assign resp_valid = !rst && r_resp_valid;
    assign result     = rst ? '0 : r_result;
    assign sr_zf      = !rst && r_zf;
    assign div_zero   = !rst && r_dz;

    // Sequencer FSM and datapath. Reset beats flush, and flush beats every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_b          <= '0;
            r_neg        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_result     <= '0;
            r_zf         <= 1'b0;
            r_dz         <= 1'b0;
        end else if (flush) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_result     <= '0;
            r_zf         <= 1'b0;
            r_dz         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_cnt <= '0;
                        r_neg <= req_signed && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                        if (!req_div) begin
                            r_b     <= w_mag_a;
                            r_acc   <= {{DATA_W{1'b0}}, w_mag_b};
                            r_state <= S_MUL;
                        end else if (operand_b == '0) begin
                            r_acc        <= '0;
                            r_resp_valid <= 1'b1;
                            r_result     <= '1;
                            r_zf         <= 1'b0;
                            r_dz         <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_b     <= w_mag_b;
                            r_acc   <= {{DATA_W{1'b0}}, w_mag_a};
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[DATA_W-1:1]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIXUP;
                end
                S_DIV: begin
                    if (w_div_ok)
                        r_acc <= {w_div_sub[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
                    else
                        r_acc <= {w_div_part[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    r_result     <= w_fix;
                    r_zf         <= (w_fix == '0);
                    r_dz         <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_result     <= '0;
                        r_zf         <= 1'b0;
                        r_dz         <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_muldiv_seq.sv
// Bench for core_muldiv_seq: table of directed MUL/DIV vectors plus hand-written
// sequences for result hold, flush, mid-operation reset and divide-by-zero.
module tb_core_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_div;
    logic        req_signed;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        sr_zf;
    logic        div_zero;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    core_muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_div    (req_div),
        .req_signed (req_signed),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .sr_zf      (sr_zf),
        .div_zero   (div_zero),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tv[14];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one request; returns just after the accepting edge (cycle T ends there).
    task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_div    = d;
        req_signed = s;
        operand_a  = a;
        operand_b  = b;
        req_valid  = 1'b1;
        check1("req_ready_at_issue", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Number of cycles after acceptance until resp_valid is seen (bounded).
    task automatic wait_resp(output int n);
        n = 1;
        @(negedge clk);
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Watch for any response over a window; returns how many cycles showed resp_valid.
    task automatic watch_none(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
    endtask

    int n;
    int seen;

    initial begin
        tv[0]  = '{1'b0, 1'b0, 32'd7,        32'd6,        32'd42,       1'b0, 1'b0, 34};
        tv[1]  = '{1'b1, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 1'b0, 34};
        tv[2]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 34};
        tv[3]  = '{1'b1, 1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1};
        tv[4]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 34};
        tv[5]  = '{1'b0, 1'b0, 32'd0,        32'd9,        32'd0,        1'b1, 1'b0, 34};
        tv[6]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 34};
        tv[7]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 34};
        tv[8]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 34};
        tv[9]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'd12,       1'b0, 1'b0, 34};
        tv[10] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0, 1'b0, 34};
        tv[11] = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 34};
        tv[12] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 34};
        tv[13] = '{1'b1, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_div    = 1'b0;
        req_signed = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_req_ready", req_ready, 1'b0);
        check1("rst_stall", stall, 1'b0);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check32("rst_result", result, 32'd0);
        check1("rst_div_zero", div_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("post_rst_req_ready", req_ready, 1'b1);
        check1("post_rst_stall", stall, 1'b0);

        // Table-driven vectors, consumer always ready
        for (int i = 0; i < 14; i++) begin
            issue(tv[i].div, tv[i].sgn, tv[i].a, tv[i].b);
            wait_resp(n);
            checkn($sformatf("v%0d_latency", i), n, tv[i].lat);
            check1($sformatf("v%0d_resp_valid", i), resp_valid, 1'b1);
            check32($sformatf("v%0d_result", i), result, tv[i].res);
            check1($sformatf("v%0d_sr_zf", i), sr_zf, tv[i].zf);
            check1($sformatf("v%0d_div_zero", i), div_zero, tv[i].dz);
            check1($sformatf("v%0d_stall_done_ready", i), stall, 1'b0);
            @(negedge clk);
            check1($sformatf("v%0d_req_ready_after", i), req_ready, 1'b1);
            check1($sformatf("v%0d_resp_valid_after", i), resp_valid, 1'b0);
            check32($sformatf("v%0d_result_after", i), result, 32'd0);
        end

        // Result held while the consumer stalls
        resp_ready = 1'b0;
        issue(1'b0, 1'b0, 32'd7, 32'd6);
        wait_resp(n);
        checkn("hold_latency", n, 34);
        for (int k = 0; k < 5; k++) begin
            check32("hold_result", result, 32'd42);
            check1("hold_stall", stall, 1'b1);
            check1("hold_resp_valid", resp_valid, 1'b1);
            check1("hold_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check1("hold_release_stall", stall, 1'b0);
        @(negedge clk);
        check1("hold_release_idle", req_ready, 1'b1);
        check1("hold_release_resp", resp_valid, 1'b0);

        // Divide by zero with the consumer stalled
        resp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'd5, 32'd0);
        wait_resp(n);
        checkn("dz_latency", n, 1);
        check32("dz_result", result, 32'hFFFFFFFF);
        check1("dz_flag", div_zero, 1'b1);
        check1("dz_zf", sr_zf, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check1("dz_stall", stall, 1'b1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check1("dz_release_idle", req_ready, 1'b1);

        // Flush at T+10 of a divide
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        repeat (9) @(negedge clk);
        check1("flush_pre_stall", stall, 1'b1);
        flush = 1'b1;
        #1;
        check1("flush_cycle_req_ready", req_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check1("flush_idle_req_ready", req_ready, 1'b1);
        check1("flush_idle_stall", stall, 1'b0);
        check1("flush_idle_resp", resp_valid, 1'b0);
        watch_none(40, seen);
        checkn("flush_no_response", seen, 0);

        // Reset at T+20 of a multiply
        issue(1'b0, 1'b0, 32'd7, 32'd6);
        @(negedge clk);
        repeat (19) @(negedge clk);
        check1("mrst_pre_stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        check1("mrst_stall", stall, 1'b0);
        check1("mrst_req_ready", req_ready, 1'b0);
        check1("mrst_resp_valid", resp_valid, 1'b0);
        check32("mrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("mrst_after_req_ready", req_ready, 1'b1);
        check1("mrst_after_stall", stall, 1'b0);
        watch_none(40, seen);
        checkn("mrst_no_response", seen, 0);

        // Flush together with resp_ready in DONE: consumed, back to IDLE
        resp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'd9, 32'd0);
        wait_resp(n);
        checkn("flushdone_latency", n, 1);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check1("flushdone_resp", resp_valid, 1'b0);
        check1("flushdone_req_ready", req_ready, 1'b1);
        check1("flushdone_div_zero", div_zero, 1'b0);

        // A normal operation still works after all the aborts
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        wait_resp(n);
        checkn("final_latency", n, 34);
        check32("final_result", result, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_muldiv_seq.md
CORE_MULDIV_SEQ -- requirements
Module: core_muldiv_seq

Iterative multiply/divide sequencer for the execute stage. It offloads OPCODE_MUL/OPCODE_DIV from the single-cycle ALU and holds the pipeline until the result is ready.

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state updates occur on the rising clock edge.
REQ-002 Port: clk  in  1  clock.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  execute stage presents a MUL/DIV operation.
REQ-005 Port: req_ready  out  1  sequencer can accept a request this cycle.
REQ-006 Port: req_div  in  1  1 = divide, 0 = multiply.
REQ-007 Port: req_signed  in  1  signed operation (ex_instr.s).
REQ-008 Port: operand_a  in  32  multiplicand or dividend.
REQ-009 Port: operand_b  in  32  multiplier or divisor.
REQ-010 Port: flush  in  1  pipeline flush; aborts any operation.
REQ-011 Port: resp_valid  out  1  result available.
REQ-012 Port: resp_ready  in  1  consumer takes the result.
REQ-013 Port: result  out  32  product low word or quotient.
REQ-014 Port: sr_zf  out  1  result == 0, valid with resp_valid.
REQ-015 Port: div_zero  out  1  divisor was 0, valid with resp_valid.
REQ-016 Port: stall  out  1  the execute stage must hold.

Function
REQ-017 States SHALL be IDLE, MUL, DIV, FIXUP and DONE.
REQ-018 req_ready SHALL equal (state==IDLE) && !flush.
REQ-019 A request is accepted only on req_valid && req_ready; on acceptance the operands, req_div and req_signed are captured and the 6-bit iteration counter is set to 0.
REQ-020 Signed requests SHALL capture operand magnitudes; the result sign is (a[31]^b[31]) for both MUL and DIV.
REQ-021 Accepted MUL SHALL go IDLE->MUL; each MUL cycle performs one shift-add step on a 64-bit accumulator.
REQ-022 Accepted DIV with operand_b != 0 SHALL go IDLE->DIV; each DIV cycle performs one restoring step producing one quotient bit, MSB first.
REQ-023 MUL and DIV SHALL each last exactly 32 cycles, counter 0..31, then go to FIXUP.
REQ-024 FIXUP SHALL take 1 cycle: it applies two's-complement negation when the result sign is 1 and req_signed=1, selects the low 32 bits, computes sr_zf, and then goes to DONE.
REQ-025 Latency: acceptance at cycle T gives resp_valid first high at T+34 for MUL and for a non-zero DIV.
REQ-026 Accepted DIV with operand_b == 0 SHALL go directly to DONE with result=32'hFFFFFFFF, div_zero=1 and sr_zf=0; resp_valid is first high at T+1.
REQ-027 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield 32'h80000000 with no exception flag.
REQ-028 In DONE, resp_valid=1 and result, sr_zf and div_zero SHALL be held stable until resp_ready=1.
REQ-029 On DONE && resp_ready the state SHALL go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-030 stall SHALL be 1 when state != IDLE, except in DONE with resp_ready=1; stall is 0 in IDLE.
REQ-031 If flush=1 in any state, the next state SHALL be IDLE, resp_valid SHALL be 0 from the next cycle, and no request is accepted in the flush cycle.
REQ-032 If flush and resp_ready occur together in DONE, the result SHALL count as consumed and the state goes to IDLE.
REQ-033 result, sr_zf and div_zero SHALL be 0 whenever resp_valid=0.
REQ-034 For unsigned operations the internal datapath SHALL use 33-bit subtraction so that no quotient bit is lost.

Reset
REQ-035 While rst=1: state=IDLE, counter=0, accumulator/remainder=0, resp_valid=0, result=0, sr_zf=0, div_zero=0, stall=0; req_ready=0 during reset.
REQ-036 rst SHALL take priority over flush and over all handshakes.
REQ-037 rst asserted in mid-operation SHALL discard that operation with no response.
REQ-038 The first request SHALL be accepted no earlier than the first cycle with rst=0.

Verification
REQ-039 Unsigned MUL 7 x 6, resp_ready=1 -> at T+34 resp_valid=1, result=42, sr_zf=0; req_ready=1 at T+35.
REQ-040 Signed DIV -100 / 7 -> result=32'hFFFFFFF2 (-14), div_zero=0; unsigned 100 / 7 -> result=14.
REQ-041 DIV 5 / 0 -> at T+1 result=32'hFFFFFFFF, div_zero=1, sr_zf=0; stall=1 until resp_ready.
REQ-042 Signed MUL 32'hFFFFFFFF x 1 -> result=32'hFFFFFFFF; MUL 0 x 9 -> result=0, sr_zf=1.
REQ-043 Hold resp_ready=0 for 5 cycles after DONE -> result stable and stall=1 throughout; on release, IDLE next cycle.
REQ-044 flush at T+10 of a DIV -> IDLE at T+11, no resp_valid; rst at T+20 of a MUL -> all outputs 0, no response.
